// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular free list of physical register IDs for rename.
// Ports: clock/reset_n (async active-low); alloc_req/alloc_valid/alloc_reg pop the head;
// free_en/free_reg push a retired mapping; ready, free_count, empty and sticky error report status.
module phys_reg_free_list #(
  parameter int REG_FILE_ADDR_WIDTH = 7,
  parameter int NUM_ARCH_REGS = 32
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           alloc_req,
  output logic                           alloc_valid,
  output logic [REG_FILE_ADDR_WIDTH-1:0] alloc_reg,
  input  logic                           free_en,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] free_reg,
  output logic                           ready,
  output logic [REG_FILE_ADDR_WIDTH-1:0] free_count,
  output logic                           empty,
  output logic                           error
);
  localparam int W = REG_FILE_ADDR_WIDTH;
  localparam int DEPTH = 2**W - NUM_ARCH_REGS;
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, init_idx_q, init_idx_d;
  logic [W-1:0] free_count_q, free_count_d;
  logic error_q, error_d;
  logic [W-1:0] entry_q [DEPTH];
  logic wr_en;
  logic [PW-1:0] wr_idx;
  logic [W-1:0] wr_data;
  logic run, pop, push, full, last_init;
  // DEPTH need not be a power of two, so wrap explicitly
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    run = state_q == RUN;
    full = free_count_q == W'(DEPTH);
    pop = run && alloc_req && free_count_q != '0;
    // a same-cycle pop frees a slot, so a push into a full list is still legal
    push = run && free_en && free_reg != '0 && (!full || pop);
    last_init = init_idx_q == PW'(DEPTH-1);
    state_d = (!run && last_init) ? RUN : state_q;
    init_idx_d = run ? init_idx_q : (last_init ? '0 : init_idx_q + PW'(1));
    head_d = pop ? nxt(head_q) : head_q;
    tail_d = push ? nxt(tail_q) : tail_q;
    free_count_d = (!run && last_init) ? W'(DEPTH) : free_count_q + W'(push) - W'(pop);
    error_d = error_q | (free_en && (!run || (free_reg != '0 && full && !pop)));
    wr_en = !run || push;
    wr_idx = run ? tail_q : init_idx_q;
    wr_data = run ? free_reg : W'(NUM_ARCH_REGS) + W'(init_idx_q);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      head_q <= '0;
      tail_q <= '0;
      init_idx_q <= '0;
      free_count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      init_idx_q <= init_idx_d;
      free_count_q <= free_count_d;
      error_q <= error_d;
    end
  end
  always_ff @(posedge clock) begin
    if (wr_en) entry_q[wr_idx] <= wr_data;
  end
  assign ready = run;
  assign alloc_valid = run && free_count_q != '0;
  assign alloc_reg = entry_q[head_q];
  assign free_count = free_count_q;
  assign empty = free_count_q == '0;
  assign error = error_q;
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: directed checks of the physical register free list.
module tb_phys_reg_free_list;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic alloc_req = 1'b0;
  logic alloc_valid;
  logic [6:0] alloc_reg;
  logic free_en = 1'b0;
  logic [6:0] free_reg = '0;
  logic ready;
  logic [6:0] free_count;
  logic empty;
  logic error;
  int n_tests = 0;
  int n_fail = 0;
  phys_reg_free_list dut (
    .clock(clock), .reset_n(reset_n), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_reg(alloc_reg), .free_en(free_en), .free_reg(free_reg), .ready(ready),
    .free_count(free_count), .empty(empty), .error(error)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic init_wait();
    int cyc = 0;
    reset_n = 1'b1;
    while (!ready && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk("init_cycles", cyc, 96);
    chk("init_count", free_count, 96);
    chk("init_head", alloc_reg, 32);
    chk("init_valid", alloc_valid, 1);
    chk("init_error", error, 0);
  endtask
  task automatic do_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_valid", alloc_valid, 0);
    chk("rst_count", free_count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_error", error, 0);
    @(negedge clock);
    init_wait();
  endtask
  initial begin
    @(negedge clock);
    @(negedge clock);
    chk("por_ready", ready, 0);
    chk("por_valid", alloc_valid, 0);
    chk("por_empty", empty, 1);
    chk("por_count", free_count, 0);
    chk("por_error", error, 0);
    init_wait();
    for (int i = 0; i < 96; i++) begin
      chk("drain_seq", alloc_reg, 32 + i);
      alloc_req = 1'b1;
      @(negedge clock);
    end
    alloc_req = 1'b0;
    chk("drain_empty", empty, 1);
    chk("drain_valid", alloc_valid, 0);
    chk("drain_count", free_count, 0);
    chk("drain_error", error, 0);
    free_en = 1'b1;
    free_reg = 7'd45;
    alloc_req = 1'b1;
    #1 chk("nobypass_valid", alloc_valid, 0);
    @(negedge clock);
    free_en = 1'b0;
    alloc_req = 1'b0;
    chk("refill_valid", alloc_valid, 1);
    chk("refill_reg", alloc_reg, 45);
    chk("refill_count", free_count, 1);
    chk("refill_error", error, 0);
    do_reset();
    alloc_req = 1'b1;
    free_en = 1'b1;
    free_reg = 7'd7;
    #1 chk("full_swap_head", alloc_reg, 32);
    @(negedge clock);
    alloc_req = 1'b0;
    chk("full_swap_error", error, 0);
    chk("full_swap_count", free_count, 96);
    chk("full_swap_next", alloc_reg, 33);
    @(negedge clock);
    free_en = 1'b0;
    chk("full_free_error", error, 1);
    chk("full_free_count", free_count, 96);
    for (int i = 0; i < 96; i++) begin
      chk("swap_seq", alloc_reg, i < 95 ? 33 + i : 7);
      alloc_req = 1'b1;
      @(negedge clock);
    end
    alloc_req = 1'b0;
    chk("swap_empty", empty, 1);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk("wrap_pop", alloc_reg, 32 + i);
      alloc_req = 1'b1;
      @(negedge clock);
    end
    alloc_req = 1'b0;
    chk("wrap_count_low", free_count, 86);
    for (int i = 1; i <= 10; i++) begin
      free_en = 1'b1;
      free_reg = 7'(i);
      @(negedge clock);
      if (i == 5) begin
        free_reg = '0;
        @(negedge clock);
        chk("zero_free_count", free_count, 91);
      end
    end
    free_en = 1'b0;
    chk("wrap_count_full", free_count, 96);
    chk("wrap_error", error, 0);
    for (int i = 0; i < 96; i++) begin
      chk("wrap_seq", alloc_reg, i < 86 ? 42 + i : i - 85);
      alloc_req = 1'b1;
      @(negedge clock);
    end
    alloc_req = 1'b0;
    chk("wrap_empty", empty, 1);
    chk("wrap_end_error", error, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
